packet_switch_dbg_poller: RTL
=============================

PACKET_SWITCH_DBG_POLLER -- requirements
Module: packet_switch_dbg_poller

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, AVMM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AVMM data and counter width.
REQ-003 SHALL have parameter NUM_REGS, default 8, number of consecutive counter registers per sweep (range 1..2^ADDR_WIDTH).
REQ-004 SHALL have parameter BASE_ADDR, default 0, address of the first counter register.
REQ-005 SHALL have parameter INTV_WIDTH, default 16, width of cfg_interval.
REQ-006 SHALL have parameter TIMEOUT, default 64, maximum number of cycles to wait for readdatavalid.
REQ-007 SHALL have port clk, input, 1, sole clock.
REQ-008 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-009 SHALL have port cfg_enable, input, 1, enables periodic sweeps.
REQ-010 SHALL have port cfg_interval, input, INTV_WIDTH, idle cycles between periodic sweeps.
REQ-011 SHALL have port sweep_trigger, input, 1, single-cycle request for one sweep.
REQ-012 SHALL have port avmm_address, output, ADDR_WIDTH, read address.
REQ-013 SHALL have port avmm_read, output, 1, read strobe.
REQ-014 SHALL have port avmm_readdata, input, DATA_WIDTH, responder data.
REQ-015 SHALL have port avmm_readdatavalid, input, 1, responder data valid.
REQ-016 SHALL have port res_tvalid, output, 1, result valid.
REQ-017 SHALL have port res_tready, input, 1, result ready.
REQ-018 SHALL have port res_tdata, output, DATA_WIDTH, counter delta.
REQ-019 SHALL have port res_tuser, output, ADDR_WIDTH+1, {timeout flag, register index}.
REQ-020 SHALL have port res_tlast, output, 1, marks the last register of the sweep.
REQ-021 SHALL have port sweep_cnt, output, 32, number of completed sweeps.
REQ-022 SHALL have port timeout_err, output, 1, sticky flag set on any read timeout.

Function
REQ-023 SHALL implement FSM states IDLE, ISSUE, WAIT_RSP, EMIT, GAP.
REQ-024 IDLE SHALL go to ISSUE with index 0 on sweep_trigger, or on cfg_enable when the gap counter is 0.
REQ-025 ISSUE SHALL drive avmm_read=1 for exactly one cycle with avmm_address=BASE_ADDR+index, then go to WAIT_RSP.
REQ-026 At most one read SHALL be outstanding; avmm_address SHALL hold until the response or timeout.
REQ-027 WAIT_RSP SHALL capture avmm_readdata on avmm_readdatavalid and go to EMIT.
REQ-028 avmm_readdatavalid in any state other than WAIT_RSP SHALL be ignored.
REQ-029 If TIMEOUT cycles elapse in WAIT_RSP without readdatavalid, the block SHALL set timeout_err, go to EMIT with delta 0 and tuser[ADDR_WIDTH]=1, and leave prev[index] unchanged.
REQ-030 On a successful read, delta SHALL equal cur-prev[index] modulo 2^DATA_WIDTH, which makes counter wrap-around correct.
REQ-031 On a successful read, prev[index] SHALL be updated to cur.
REQ-032 EMIT SHALL hold res_tvalid and the payload stable until res_tready; output SHALL NOT depend combinationally on res_tready.
REQ-033 res_tlast SHALL be 1 only for index NUM_REGS-1.
REQ-034 After the handshake, EMIT SHALL go to ISSUE with index+1, or to GAP after the last index.
REQ-035 On sweep completion, sweep_cnt SHALL increment, wrapping at 2^32.
REQ-036 GAP SHALL load the gap counter with cfg_interval and return to IDLE; the gap counter SHALL decrement in IDLE while nonzero.
REQ-037 sweep_trigger received during a sweep SHALL be latched as pending and SHALL start a sweep on the next IDLE, bypassing the gap.
REQ-038 Deasserting cfg_enable mid-sweep SHALL let the current sweep complete.

Reset
REQ-039 While rst=0 on a clk edge: state=IDLE, avmm_read=0, avmm_address=0, res_tvalid=0, res_tdata=0, res_tuser=0, res_tlast=0, sweep_cnt=0, timeout_err=0, all prev[]=0, gap counter=0, pending=0.
REQ-040 Reset asserted mid-sweep SHALL abort the sweep without emitting partial results.

Structure
REQ-041 The FSM state enum SHALL be added to packet_switch_pkg as dbg_poller_state_t.
REQ-042 The default poll register count and TIMEOUT SHALL be package constants.
REQ-043 The prev[] storage SHALL be a flop array.
REQ-044 The block SHALL be a single module with no sub-module.

Verification
REQ-045 Reset, then sweep_trigger with responder values 10..17 and a fixed 2-cycle latency -> 8 results with deltas 10..17, tlast on index 7, sweep_cnt=1.
REQ-046 Second sweep with values 15..22 -> every delta equals 5.
REQ-047 prev=0xFFFF_FFF0, cur=0x0000_0010 -> delta 0x20.
REQ-048 Responder silent on index 3 -> after 64 cycles, result index 3 has delta 0, tuser[8]=1, timeout_err=1; the next sweep's index 3 delta is computed from the old prev.
REQ-049 res_tready held low 20 cycles during EMIT -> payload stable and no further avmm_read issued.
REQ-050 cfg_enable=1, cfg_interval=100 -> consecutive sweep starts are 100 idle cycles apart; sweep_trigger during a sweep -> the next sweep starts immediately after it; rst=0 mid-sweep -> all outputs return to their reset values.

Source files
------------

// File: rtl/packet_switch_pkg.sv
// Shared types and defaults for the packet switch blocks.
// Holds the debug counter poller state encoding and its default sizing constants.
package packet_switch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        EMIT,
        GAP
    } dbg_poller_state_t;

    localparam int DBG_POLL_NUM_REGS = 8;
    localparam int DBG_POLL_TIMEOUT  = 64;

endpackage

// File: rtl/packet_switch_dbg_poller.sv
// Periodically sweeps a block of AVMM counter registers and streams per-register
// deltas (current minus previously read value) out on a valid/ready result port.
module packet_switch_dbg_poller
    import packet_switch_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = DBG_POLL_NUM_REGS,
    parameter int BASE_ADDR  = 0,
    parameter int INTV_WIDTH = 16,
    parameter int TIMEOUT    = DBG_POLL_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_enable,
    input  logic [INTV_WIDTH-1:0]   cfg_interval,
    input  logic                    sweep_trigger,
    output logic [ADDR_WIDTH-1:0]   avmm_address,
    output logic                    avmm_read,
    input  logic [DATA_WIDTH-1:0]   avmm_readdata,
    input  logic                    avmm_readdatavalid,
    output logic                    res_tvalid,
    input  logic                    res_tready,
    output logic [DATA_WIDTH-1:0]   res_tdata,
    output logic [ADDR_WIDTH:0]     res_tuser,
    output logic                    res_tlast,
    output logic [31:0]             sweep_cnt,
    output logic                    timeout_err,
    output dbg_poller_state_t       state_dbg
);

    // Result port: res_tvalid rises only in EMIT and the payload is held in registers
    // until the cycle where res_tvalid && res_tready, so nothing here depends
    // combinationally on res_tready.

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]       TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

    dbg_poller_state_t state, state_next;

    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] idx_inc;
    logic [IDX_W-1:0]      pidx;
    logic [TO_W-1:0]       to_cnt;
    logic [INTV_WIDTH-1:0] gap_cnt;
    logic                  pending;
    logic [DATA_WIDTH-1:0] prev [NUM_REGS];

    logic start_sweep;
    logic rsp_ok;
    logic rsp_to;
    logic advance;
    logic finish;
    logic is_last;

    assign idx_inc    = idx + 1'b1;
    assign pidx       = idx[IDX_W-1:0];
    assign is_last    = (idx == LAST_IDX);
    assign avmm_read  = (state == ISSUE);
    assign res_tvalid = (state == EMIT);
    assign state_dbg  = state;

    always_comb begin
        state_next  = state;
        start_sweep = 1'b0;
        rsp_ok      = 1'b0;
        rsp_to      = 1'b0;
        advance     = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                if (sweep_trigger || pending || (cfg_enable && gap_cnt == '0)) begin
                    start_sweep = 1'b1;
                    state_next  = ISSUE;
                end
            end
            ISSUE: state_next = WAIT_RSP;
            WAIT_RSP: begin
                if (avmm_readdatavalid) begin
                    rsp_ok     = 1'b1;
                    state_next = EMIT;
                end else if (to_cnt == TO_LAST) begin
                    rsp_to     = 1'b1;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (res_tready) begin
                    if (is_last) begin
                        finish     = 1'b1;
                        state_next = GAP;
                    end else begin
                        advance    = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            idx          <= '0;
            avmm_address <= '0;
            to_cnt       <= '0;
            gap_cnt      <= '0;
            pending      <= 1'b0;
            res_tdata    <= '0;
            res_tuser    <= '0;
            res_tlast    <= 1'b0;
            sweep_cnt    <= '0;
            timeout_err  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                prev[i] <= '0;
            end
        end else begin
            state <= state_next;

            // The address register only moves when a new read is about to be issued,
            // so it stays put across WAIT_RSP and EMIT.
            if (start_sweep) begin
                idx          <= '0;
                avmm_address <= BASE;
            end else if (advance) begin
                idx          <= idx_inc;
                avmm_address <= BASE + idx_inc;
            end

            if (state == ISSUE) begin
                to_cnt <= '0;
            end else if (state == WAIT_RSP) begin
                to_cnt <= to_cnt + 1'b1;
            end

            // A trigger seen outside IDLE is remembered and bypasses the gap later.
            if (start_sweep) begin
                pending <= 1'b0;
            end else if (sweep_trigger) begin
                pending <= 1'b1;
            end

            if (state == GAP) begin
                gap_cnt <= cfg_interval;
            end else if (state == IDLE && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end

            if (rsp_ok) begin
                res_tdata  <= avmm_readdata - prev[pidx];
                res_tuser  <= {1'b0, idx};
                res_tlast  <= is_last;
                prev[pidx] <= avmm_readdata;
            end else if (rsp_to) begin
                res_tdata   <= '0;
                res_tuser   <= {1'b1, idx};
                res_tlast   <= is_last;
                timeout_err <= 1'b1;
            end

            if (finish) begin
                sweep_cnt <= sweep_cnt + 32'd1;
            end
        end
    end

endmodule
